// File: rtl/wb_regfile.sv
// Write-back stage with integrated 31-entry register file, write-through
// bypass on both read ports and a 64-bit retired-instruction counter.

module wb_regfile_rdport (
  input  logic [4:0]        addr,
  input  logic [31:0][31:0] regs,
  input  logic              wr,
  input  logic [4:0]        rd,
  input  logic [31:0]       result,
  input  logic              rst_n,
  output logic [31:0]       data
);
  always_comb begin
    data = '0;
    if (rst_n && addr != 5'd0) begin
      if (wr && addr == rd) data = result;
      else                  data = regs[addr];
    end
  end
endmodule

module wb_regfile (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] WB_ALU_Result,
  input  logic [31:0] WB_PC_Plus4,
  input  logic [31:0] WB_Read_Data,
  input  logic [31:0] WB_Instr,
  input  logic [4:0]  ID_Rs1_Addr,
  input  logic [4:0]  ID_Rs2_Addr,
  output logic [31:0] Rs1_Data,
  output logic [31:0] Rs2_Data,
  output logic        WB_Reg_Write,
  output logic [4:0]  WB_Rd_Addr,
  output logic [31:0] WB_Result,
  output logic [63:0] Instret
);
  localparam int NUM_RD = 2;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [1:0]  off;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        wr_class;
  logic [31:0] regs [1:31];
  logic [31:0][31:0] rd_view;
  logic [NUM_RD-1:0][4:0]  raddr;
  logic [NUM_RD-1:0][31:0] rdata;
  logic [63:0] instret_q;

  assign opcode     = WB_Instr[6:0];
  assign WB_Rd_Addr = WB_Instr[11:7];
  assign funct3     = WB_Instr[14:12];
  assign off        = WB_ALU_Result[1:0];

  always_comb begin
    ld_byte = WB_Read_Data[7:0];
    case (off)
      2'd1:    ld_byte = WB_Read_Data[15:8];
      2'd2:    ld_byte = WB_Read_Data[23:16];
      2'd3:    ld_byte = WB_Read_Data[31:24];
      default: ld_byte = WB_Read_Data[7:0];
    endcase
  end

  assign ld_half = off[1] ? WB_Read_Data[31:16] : WB_Read_Data[15:0];

  always_comb begin
    wr_class  = 1'b0;
    WB_Result = '0;
    case (opcode)
      7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111: begin
        wr_class  = 1'b1;
        WB_Result = WB_ALU_Result;
      end
      7'b1101111, 7'b1100111: begin
        wr_class  = 1'b1;
        WB_Result = WB_PC_Plus4;
      end
      7'b0000011: begin
        wr_class = 1'b1;
        case (funct3)
          3'b000:  WB_Result = {{24{ld_byte[7]}}, ld_byte};
          3'b100:  WB_Result = {24'h0, ld_byte};
          3'b001:  WB_Result = {{16{ld_half[15]}}, ld_half};
          3'b101:  WB_Result = {16'h0, ld_half};
          3'b010:  WB_Result = WB_Read_Data;
          default: wr_class  = 1'b0;
        endcase
      end
      default: ;
    endcase
  end

  assign WB_Reg_Write = wr_class && (WB_Rd_Addr != 5'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < 32; i++) regs[i] <= '0;
    end else if (WB_Reg_Write) begin
      regs[WB_Rd_Addr] <= WB_Result;
    end
  end

  // Entry 0 is a hardwired zero so the read ports can index a full 32-entry view.
  assign rd_view[0] = '0;
  for (genvar g = 1; g < 32; g++) begin : g_view
    assign rd_view[g] = regs[g];
  end

  assign raddr = {ID_Rs2_Addr, ID_Rs1_Addr};

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    wb_regfile_rdport u_rdport (
      .addr   (raddr[p]),
      .regs   (rd_view),
      .wr     (WB_Reg_Write),
      .rd     (WB_Rd_Addr),
      .result (WB_Result),
      .rst_n  (rst_n),
      .data   (rdata[p])
    );
  end

  assign Rs1_Data = rdata[0];
  assign Rs2_Data = rdata[1];

  // Every non-bubble 32-bit encoding retires, including stores and branches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   instret_q <= '0;
    else if (WB_Instr != '0 && WB_Instr[1:0] == 2'b11) instret_q <= instret_q + 64'd1;
  end

  assign Instret = instret_q;
endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: stimulus queues expected values, a negedge
// monitor pops and compares them against the DUT.
`timescale 1ns/1ps

module tb_wb_regfile;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] alu = '0, pc4 = '0, rdat = '0, instr = '0;
  logic [4:0]  a1 = '0, a2 = '0;
  logic [31:0] rs1, rs2, result;
  logic        reg_write;
  logic [4:0]  rd_addr;
  logic [63:0] instret;

  localparam int S_RS1 = 0, S_RS2 = 1, S_WR = 2, S_RD = 3, S_RES = 4, S_IRET = 5;

  typedef struct {
    string       name;
    int          sel;
    logic [63:0] exp;
  } chk_t;

  chk_t chk_q[$];
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .WB_ALU_Result (alu),
    .WB_PC_Plus4   (pc4),
    .WB_Read_Data  (rdat),
    .WB_Instr      (instr),
    .ID_Rs1_Addr   (a1),
    .ID_Rs2_Addr   (a2),
    .Rs1_Data      (rs1),
    .Rs2_Data      (rs2),
    .WB_Reg_Write  (reg_write),
    .WB_Rd_Addr    (rd_addr),
    .WB_Result     (result),
    .Instret       (instret)
  );

  function automatic logic [63:0] actual(int sel);
    case (sel)
      S_RS1:   return {32'h0, rs1};
      S_RS2:   return {32'h0, rs2};
      S_WR:    return {63'h0, reg_write};
      S_RD:    return {59'h0, rd_addr};
      S_RES:   return {32'h0, result};
      default: return instret;
    endcase
  endfunction

  // Monitor: everything queued during a cycle is checked at its falling edge.
  always @(negedge clk) begin
    while (chk_q.size() > 0) begin
      chk_t c;
      logic [63:0] act;
      c   = chk_q.pop_front();
      act = actual(c.sel);
      n_total++;
      if (act === c.exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", c.name, act, c.exp);
    end
  end

  task automatic expect_val(string name, int sel, logic [63:0] exp);
    chk_t c;
    c.name = name; c.sel = sel; c.exp = exp;
    chk_q.push_back(c);
  endtask

  task automatic drive(logic [31:0] i, logic [31:0] a, logic [31:0] p,
                       logic [31:0] d, logic [4:0] r1, logic [4:0] r2);
    instr = i; alu = a; pc4 = p; rdat = d; a1 = r1; a2 = r2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] load_instr(logic [2:0] f3);
    return {17'h0, f3, 5'd6, 7'b0000011};
  endfunction

  initial begin
    // Reset held: reads are 0 and the counter is clear.
    drive(32'h0, 32'h0, 32'h0, 32'h0, 5'd5, 5'd0);
    tick();
    expect_val("rst_rs1", S_RS1, 64'h0);
    expect_val("rst_instret", S_IRET, 64'h0);
    tick();
    rst_n = 1'b1;

    // Ten bubble cycles do not retire.
    for (int k = 0; k < 10; k++) tick();
    expect_val("bubble_rs1_x5", S_RS1, 64'h0);
    expect_val("bubble_instret", S_IRET, 64'h0);
    tick();

    // ADDI x5, 10: same-cycle bypass on both ports.
    drive(32'h00A00293, 32'h0000000A, 32'h0, 32'h0, 5'd5, 5'd5);
    expect_val("addi_wr", S_WR, 64'h1);
    expect_val("addi_rd", S_RD, 64'h5);
    expect_val("addi_result", S_RES, 64'hA);
    expect_val("addi_byp_rs1", S_RS1, 64'hA);
    expect_val("addi_byp_rs2", S_RS2, 64'hA);
    expect_val("addi_instret_pre", S_IRET, 64'h0);
    tick();
    drive(32'h0, 32'h0, 32'h0, 32'h0, 5'd5, 5'd0);
    expect_val("x5_stored", S_RS1, 64'hA);
    expect_val("instret_1", S_IRET, 64'h1);
    expect_val("bubble_wr", S_WR, 64'h0);
    expect_val("bubble_result", S_RES, 64'h0);
    tick();

    // Loads into x6 from 0x8081F0FF.
    drive(load_instr(3'b000), 32'h2, 32'h0, 32'h8081F0FF, 5'd6, 5'd0);
    expect_val("lb_off2", S_RES, 64'hFFFFFF81);
    expect_val("lb_byp", S_RS1, 64'hFFFFFF81);
    expect_val("lb_instret", S_IRET, 64'h1);
    tick();
    drive(load_instr(3'b100), 32'h2, 32'h0, 32'h8081F0FF, 5'd6, 5'd0);
    expect_val("lbu_off2", S_RES, 64'h00000081);
    tick();
    drive(load_instr(3'b001), 32'h2, 32'h0, 32'h8081F0FF, 5'd6, 5'd0);
    expect_val("lh_off2", S_RES, 64'hFFFF8081);
    tick();
    drive(load_instr(3'b101), 32'h2, 32'h0, 32'h8081F0FF, 5'd6, 5'd0);
    expect_val("lhu_off2", S_RES, 64'h00008081);
    tick();
    drive(load_instr(3'b010), 32'h2, 32'h0, 32'h8081F0FF, 5'd6, 5'd0);
    expect_val("lw_off2", S_RES, 64'h8081F0FF);
    tick();
    drive(load_instr(3'b000), 32'h0, 32'h0, 32'h8081F0FF, 5'd6, 5'd0);
    expect_val("lb_off0", S_RES, 64'hFFFFFFFF);
    tick();
    drive(load_instr(3'b100), 32'h1, 32'h0, 32'h8081F0FF, 5'd6, 5'd0);
    expect_val("lbu_off1", S_RES, 64'h000000F0);
    tick();
    drive(load_instr(3'b001), 32'h1, 32'h0, 32'h8081F0FF, 5'd6, 5'd0);
    expect_val("lh_off1", S_RES, 64'hFFFFF0FF);
    tick();
    drive(load_instr(3'b010), 32'h3, 32'h0, 32'h8081F0FF, 5'd6, 5'd0);
    expect_val("lw_off3", S_RES, 64'h8081F0FF);
    tick();
    drive(load_instr(3'b011), 32'h2, 32'h0, 32'h8081F0FF, 5'd6, 5'd0);
    expect_val("ld_bad_f3_wr", S_WR, 64'h0);
    expect_val("ld_bad_f3_res", S_RES, 64'h0);
    expect_val("ld_bad_f3_rs1", S_RS1, 64'h8081F0FF);
    expect_val("loads_instret", S_IRET, 64'd10);
    tick();

    // ADDI x0, x0 with a nonzero ALU result: no write, still retires.
    drive(32'h00000013, 32'hDEADBEEF, 32'h0, 32'h0, 5'd0, 5'd6);
    expect_val("x0_wr", S_WR, 64'h0);
    expect_val("x0_read", S_RS1, 64'h0);
    expect_val("x0_result", S_RES, 64'hDEADBEEF);
    expect_val("x6_stored", S_RS2, 64'h8081F0FF);
    tick();
    drive(32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
    expect_val("x0_instret", S_IRET, 64'd12);
    expect_val("x0_after", S_RS1, 64'h0);
    tick();

    // JAL x1 writes PC+4.
    drive(32'h000000EF, 32'h12345678, 32'h00000104, 32'h0, 5'd5, 5'd1);
    expect_val("jal_wr", S_WR, 64'h1);
    expect_val("jal_byp_rs2", S_RS2, 64'h104);
    tick();
    drive(32'h0, 32'h0, 32'h0, 32'h0, 5'd1, 5'd0);
    expect_val("x1_stored", S_RS1, 64'h104);
    tick();

    // Store: no write, retires.
    drive(32'h0000A023, 32'h00000055, 32'h0, 32'h0, 5'd5, 5'd0);
    expect_val("store_wr", S_WR, 64'h0);
    expect_val("store_res", S_RES, 64'h0);
    expect_val("store_x5", S_RS1, 64'hA);
    expect_val("store_instret_pre", S_IRET, 64'd13);
    tick();
    drive(32'h0, 32'h0, 32'h0, 32'h0, 5'd5, 5'd0);
    expect_val("store_instret_post", S_IRET, 64'd14);
    tick();

    // Counter wrap from all ones.
    force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.instret_q;
    drive(32'h00A00293, 32'h0000000A, 32'h0, 32'h0, 5'd5, 5'd0);
    expect_val("instret_max", S_IRET, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    drive(32'h0, 32'h0, 32'h0, 32'h0, 5'd5, 5'd0);
    expect_val("instret_wrap", S_IRET, 64'h0);
    tick();

    // Reset lands between edges while a write to x7 is pending.
    drive(32'h00000393, 32'h00000077, 32'h0, 32'h0, 5'd7, 5'd5);
    #2;
    rst_n = 1'b0;
    expect_val("rst_mid_rs1", S_RS1, 64'h0);
    expect_val("rst_mid_wr_follows", S_WR, 64'h1);
    expect_val("rst_mid_res_follows", S_RES, 64'h77);
    expect_val("rst_mid_instret", S_IRET, 64'h0);
    tick();
    rst_n = 1'b1;
    drive(32'h0, 32'h0, 32'h0, 32'h0, 5'd7, 5'd5);
    expect_val("x7_after_rst", S_RS1, 64'h0);
    expect_val("x5_after_rst", S_RS2, 64'h0);
    expect_val("instret_after_rst", S_IRET, 64'h0);
    tick();

    // Resumes normally after reset release.
    drive(32'h00000393, 32'h00000077, 32'h0, 32'h0, 5'd0, 5'd0);
    tick();
    drive(32'h0, 32'h0, 32'h0, 32'h0, 5'd7, 5'd0);
    expect_val("x7_resume", S_RS1, 64'h77);
    expect_val("instret_resume", S_IRET, 64'h1);
    tick();
    tick();

    if (chk_q.size() != 0) begin
      n_total++;
      $display("FAIL drain: %0d checks left unchecked, expected 0", chk_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
